// File: rtl/t05_find_least.sv
// t05_find_least: scans the completed byte histogram, reports the two
// smallest nonzero counts and clears both winning bins so that the next
// invocation continues up the histogram in ascending count order.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active low
//   en_state   top-level FSM state; this block runs while it equals MY_STATE
//   sram_in    histogram read data, valid the cycle after an accepted read
//   sram_busy  SRAM stall; a command issued while high is not accepted
//   hist_addr  histogram address
//   wr_r_en    SRAM command: 00 idle, 01 read, 10 write
//   sram_out   histogram write data (always zero: bins are cleared)
//   least1     index of the smallest nonzero count
//   least2     index of the second-smallest nonzero count
//   cnt1/cnt2  counts at least1/least2
//   sum        cnt1 + cnt2, one bit wider so it never overflows
//   found      number of nonzero bins located (0..2)
//   complete   one-cycle pulse when the result outputs are fresh
module t05_find_least #(
    parameter int          NUM_BINS = 256,
    parameter int          CNT_W    = 32,
    parameter logic [3:0]  MY_STATE = 4'd2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         en_state,
    input  logic [CNT_W-1:0]   sram_in,
    input  logic               sram_busy,
    output logic [7:0]         hist_addr,
    output logic [1:0]         wr_r_en,
    output logic [CNT_W-1:0]   sram_out,
    output logic [7:0]         least1,
    output logic [7:0]         least2,
    output logic [CNT_W-1:0]   cnt1,
    output logic [CNT_W-1:0]   cnt2,
    output logic [CNT_W:0]     sum,
    output logic [1:0]         found,
    output logic               complete
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_CLEAR1 = 3'd3,
        ST_CLEAR2 = 3'd4,
        ST_DONE   = 3'd5,
        ST_WAIT   = 3'd6
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_BINS - 1);
    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_WR   = 2'b10;

    state_t             state_q, state_d;
    logic [7:0]         ptr_q, ptr_d;
    logic               pend_q, pend_d;          // a read was accepted last cycle
    logic [7:0]         pend_idx_q, pend_idx_d;  // index of that read

    // Running trackers; validity flags instead of sentinels so that an
    // all-ones count is still a legal candidate.
    logic [7:0]         trk_l1_q, trk_l1_d, trk_l2_q, trk_l2_d;
    logic [CNT_W-1:0]   trk_c1_q, trk_c1_d, trk_c2_q, trk_c2_d;
    logic               trk_v1_q, trk_v1_d, trk_v2_q, trk_v2_d;

    logic [7:0]         hist_addr_q, hist_addr_d;
    logic [1:0]         wr_r_en_q, wr_r_en_d;
    logic [7:0]         least1_q, least1_d, least2_q, least2_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [CNT_W:0]     sum_q, sum_d;
    logic [1:0]         found_q, found_d;
    logic               complete_q, complete_d;

    logic               run_s;
    logic               load_s;
    logic [CNT_W-1:0]   res_c1_s, res_c2_s;

    assign run_s = (en_state == MY_STATE);

    // Tracker update: insert each sampled nonzero count into the sorted pair.
    always_comb begin
        trk_l1_d = trk_l1_q;
        trk_c1_d = trk_c1_q;
        trk_v1_d = trk_v1_q;
        trk_l2_d = trk_l2_q;
        trk_c2_d = trk_c2_q;
        trk_v2_d = trk_v2_q;
        if ((state_q == ST_IDLE) && run_s) begin
            trk_l1_d = 8'd0;
            trk_c1_d = {CNT_W{1'b0}};
            trk_v1_d = 1'b0;
            trk_l2_d = 8'd0;
            trk_c2_d = {CNT_W{1'b0}};
            trk_v2_d = 1'b0;
        end else if (((state_q == ST_SCAN) || (state_q == ST_DRAIN)) && run_s
                     && pend_q && (sram_in != {CNT_W{1'b0}})) begin
            // Strict less-than: on ties the earlier (lower) index stays ahead.
            if (!trk_v1_q || (sram_in < trk_c1_q)) begin
                trk_l2_d = trk_l1_q;
                trk_c2_d = trk_c1_q;
                trk_v2_d = trk_v1_q;
                trk_l1_d = pend_idx_q;
                trk_c1_d = sram_in;
                trk_v1_d = 1'b1;
            end else if (!trk_v2_q || (sram_in < trk_c2_q)) begin
                trk_l2_d = pend_idx_q;
                trk_c2_d = sram_in;
                trk_v2_d = 1'b1;
            end else begin
                trk_v2_d = trk_v2_q;
            end
        end else begin
            trk_v1_d = trk_v1_q;
        end
    end

    // Next-state logic, read pointer and pending-sample bookkeeping.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        pend_d     = 1'b0;
        pend_idx_d = pend_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (run_s) begin
                    state_d = ST_SCAN;
                    ptr_d   = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!run_s) begin
                    state_d = ST_IDLE;
                end else if (!sram_busy) begin
                    pend_d     = 1'b1;
                    pend_idx_d = ptr_q;
                    ptr_d      = ptr_q + 8'd1;
                    if (ptr_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DRAIN: begin
                // Decide on the clears using the trackers including the last datum.
                if (!run_s) begin
                    state_d = ST_IDLE;
                end else if (trk_v1_d) begin
                    state_d = ST_CLEAR1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_CLEAR1: begin
                if (!run_s) begin
                    state_d = ST_IDLE;
                end else if (!sram_busy) begin
                    state_d = trk_v2_q ? ST_CLEAR2 : ST_DONE;
                end else begin
                    state_d = ST_CLEAR1;
                end
            end
            ST_CLEAR2: begin
                if (!run_s) begin
                    state_d = ST_IDLE;
                end else if (!sram_busy) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CLEAR2;
                end
            end
            ST_DONE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!run_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs: the SRAM command is derived from the state being
    // entered, so it is presented for the whole cycle spent in that state.
    always_comb begin
        hist_addr_d = hist_addr_q;
        wr_r_en_d   = CMD_IDLE;
        least1_d    = least1_q;
        least2_d    = least2_q;
        cnt1_d      = cnt1_q;
        cnt2_d      = cnt2_q;
        sum_d       = sum_q;
        found_d     = found_q;
        complete_d  = 1'b0;
        case (state_d)
            ST_SCAN: begin
                hist_addr_d = ptr_d;
                wr_r_en_d   = CMD_RD;
            end
            ST_CLEAR1: begin
                hist_addr_d = trk_l1_d;
                wr_r_en_d   = CMD_WR;
            end
            ST_CLEAR2: begin
                hist_addr_d = trk_l2_d;
                wr_r_en_d   = CMD_WR;
            end
            default: begin
                wr_r_en_d = CMD_IDLE;
            end
        endcase
        if (load_s) begin
            least1_d   = trk_v1_d ? trk_l1_d : 8'd0;
            least2_d   = trk_v2_d ? trk_l2_d : 8'd0;
            cnt1_d     = res_c1_s;
            cnt2_d     = res_c2_s;
            sum_d      = {1'b0, res_c1_s} + {1'b0, res_c2_s};
            found_d    = {1'b0, trk_v1_d} + {1'b0, trk_v2_d};
            complete_d = 1'b1;
        end else begin
            complete_d = 1'b0;
        end
    end

    assign load_s   = (state_d == ST_DONE) && (state_q != ST_DONE);
    assign res_c1_s = trk_v1_d ? trk_c1_d : {CNT_W{1'b0}};
    assign res_c2_s = trk_v2_d ? trk_c2_d : {CNT_W{1'b0}};

    // State, tracker and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 8'd0;
            pend_q      <= 1'b0;
            pend_idx_q  <= 8'd0;
            trk_l1_q    <= 8'd0;
            trk_c1_q    <= {CNT_W{1'b0}};
            trk_v1_q    <= 1'b0;
            trk_l2_q    <= 8'd0;
            trk_c2_q    <= {CNT_W{1'b0}};
            trk_v2_q    <= 1'b0;
            hist_addr_q <= 8'd0;
            wr_r_en_q   <= CMD_IDLE;
            least1_q    <= 8'd0;
            least2_q    <= 8'd0;
            cnt1_q      <= {CNT_W{1'b0}};
            cnt2_q      <= {CNT_W{1'b0}};
            sum_q       <= {(CNT_W+1){1'b0}};
            found_q     <= 2'd0;
            complete_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            pend_q      <= pend_d;
            pend_idx_q  <= pend_idx_d;
            trk_l1_q    <= trk_l1_d;
            trk_c1_q    <= trk_c1_d;
            trk_v1_q    <= trk_v1_d;
            trk_l2_q    <= trk_l2_d;
            trk_c2_q    <= trk_c2_d;
            trk_v2_q    <= trk_v2_d;
            hist_addr_q <= hist_addr_d;
            wr_r_en_q   <= wr_r_en_d;
            least1_q    <= least1_d;
            least2_q    <= least2_d;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
            sum_q       <= sum_d;
            found_q     <= found_d;
            complete_q  <= complete_d;
        end
    end

    assign hist_addr = hist_addr_q;
    assign wr_r_en   = wr_r_en_q;
    assign sram_out  = {CNT_W{1'b0}};
    assign least1    = least1_q;
    assign least2    = least2_q;
    assign cnt1      = cnt1_q;
    assign cnt2      = cnt2_q;
    assign sum       = sum_q;
    assign found     = found_q;
    assign complete  = complete_q;

endmodule
